// File: rtl/verificador_secuencia_pkg.sv
// Shared definitions for the 10-step counter sequence: length, value table,
// checker state encoding and index stepping. Generator and checker both use it.
package verificador_secuencia_pkg;

  localparam int LONG_SECUENCIA = 10;

  // Sequence values in period order; position 0 (value 3) is the only 3.
  localparam logic [3:0] SECUENCIA [LONG_SECUENCIA] = '{
    4'd3, 4'd7, 4'd6, 4'd6, 4'd15, 4'd14, 4'd7, 4'd10, 4'd12, 4'd14
  };

  // Index of the last position; matching here completes a period.
  localparam logic [3:0] ULTIMO_INDICE = 4'(LONG_SECUENCIA - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } estadoT;

  // Next position in the period, wrapping the last one back to 0.
  function automatic logic [3:0] siguienteIndice(input logic [3:0] indice);
    return (indice == ULTIMO_INDICE) ? 4'd0 : indice + 4'd1;
  endfunction

endpackage

// File: rtl/rom_secuencia.sv
// Combinational lookup of the sequence value at a given position.
// Positions 10..15 do not exist in the period and read as 0.
module rom_secuencia
  import verificador_secuencia_pkg::*;
(
  input  logic [3:0] indice,
  output logic [3:0] valor
);

  logic [3:0] tabla [16];

  // Build the full 16-entry table so any 4-bit index has a defined value.
  for (genvar gi = 0; gi < 16; gi++) begin : gTabla
    if (gi < LONG_SECUENCIA) begin : gValido
      assign tabla[gi] = SECUENCIA[gi];
    end else begin : gVacio
      assign tabla[gi] = 4'd0;
    end
  end

  assign valor = tabla[indice];

endmodule

// File: rtl/verificador_secuencia.sv
// Receive-side checker: hunts for the unique value 3 to lock onto the
// sequence phase, then compares each valid sample against the expected
// value, pulsing Error on mismatches and counting completed periods.
// Too many consecutive mismatches drop the lock and hunting restarts.
module verificador_secuencia #(
  parameter int MAX_FALLOS = 3,
  parameter int VUELTAS_W  = 8
) (
  input  logic                 C,
  input  logic                 R,
  input  logic [3:0]           Valor,
  input  logic                 Valido,
  output logic                 Sincronizado,
  output logic                 Error,
  output logic [3:0]           Indice,
  output logic [3:0]           Esperado,
  output logic [VUELTAS_W-1:0] Vueltas
);

  import verificador_secuencia_pkg::*;

  localparam logic [3:0]           LIMITE_FALLOS = 4'(MAX_FALLOS);
  localparam logic [VUELTAS_W-1:0] UNO_VUELTA    = VUELTAS_W'(1);

  estadoT               estadoReg;
  logic [3:0]           indiceReg;
  logic [3:0]           fallosReg;
  logic [VUELTAS_W-1:0] vueltasReg;
  logic                 errorReg;
  logic                 sincronizadoReg;
  logic [3:0]           esperadoRom;
  logic [3:0]           fallosInc;
  logic                 vueltasLlenas;

  // Expected value is a pure decode of the current position.
  rom_secuencia uRom (
    .indice (indiceReg),
    .valor  (esperadoRom)
  );

  assign fallosInc     = fallosReg + 4'd1;
  assign vueltasLlenas = &vueltasReg;

  // Lock/check state machine with registered status outputs.
  always_ff @(posedge C) begin
    if (R) begin
      estadoReg       <= HUNT;
      indiceReg       <= 4'd0;
      fallosReg       <= 4'd0;
      vueltasReg      <= '0;
      errorReg        <= 1'b0;
      sincronizadoReg <= 1'b0;
    end else begin
      errorReg <= 1'b0;
      if (Valido) begin
        case (estadoReg)
          HUNT: begin
            // 3 occurs once per period, so seeing it fixes the phase.
            if (Valor == SECUENCIA[0]) begin
              estadoReg       <= LOCKED;
              indiceReg       <= 4'd1;
              fallosReg       <= 4'd0;
              sincronizadoReg <= 1'b1;
            end
          end
          LOCKED: begin
            if (Valor == esperadoRom) begin
              fallosReg <= 4'd0;
              indiceReg <= siguienteIndice(indiceReg);
              if (indiceReg == ULTIMO_INDICE && !vueltasLlenas) begin
                vueltasReg <= vueltasReg + UNO_VUELTA;
              end
            end else begin
              // A mismatch is a corrupted sample, not a slip: keep stepping.
              errorReg <= 1'b1;
              if (fallosInc == LIMITE_FALLOS) begin
                estadoReg       <= HUNT;
                indiceReg       <= 4'd0;
                fallosReg       <= 4'd0;
                sincronizadoReg <= 1'b0;
              end else begin
                fallosReg <= fallosInc;
                indiceReg <= siguienteIndice(indiceReg);
              end
            end
          end
          default: begin
            estadoReg       <= HUNT;
            indiceReg       <= 4'd0;
            fallosReg       <= 4'd0;
            sincronizadoReg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Sincronizado = sincronizadoReg;
  assign Error        = errorReg;
  assign Indice       = indiceReg;
  assign Esperado     = esperadoRom;
  assign Vueltas      = vueltasReg;

endmodule

// File: tb/tb_verificador_secuencia.sv
// Scoreboard bench: each stimulus cycle pushes its hand-computed expected
// outputs; a monitor pops and compares one entry after every rising edge.
// A second instance with a 2-bit period counter checks saturation.
module tb_verificador_secuencia;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic [3:0] Valor = 4'd0;
  logic       Valido = 1'b0;

  logic       sinc1, err1;
  logic [3:0] idx1, esp1;
  logic [7:0] vue1;
  logic       sinc2, err2;
  logic [3:0] idx2, esp2;
  logic [1:0] vue2;

  always #5 C = ~C;

  verificador_secuencia #(.MAX_FALLOS(3), .VUELTAS_W(8)) dut (
    .C(C), .R(R), .Valor(Valor), .Valido(Valido),
    .Sincronizado(sinc1), .Error(err1), .Indice(idx1),
    .Esperado(esp1), .Vueltas(vue1)
  );

  verificador_secuencia #(.MAX_FALLOS(3), .VUELTAS_W(2)) dutSat (
    .C(C), .R(R), .Valor(Valor), .Valido(Valido),
    .Sincronizado(sinc2), .Error(err2), .Indice(idx2),
    .Esperado(esp2), .Vueltas(vue2)
  );

  // Period values, written out by hand for the expected Esperado output.
  int secRef [10] = '{3, 7, 6, 6, 15, 14, 7, 10, 12, 14};

  typedef struct {
    string name;
    int    sinc;
    int    err;
    int    idx;
    int    esp;
    int    vue;
    int    vueSat;
  } expT;

  expT q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", n, act, req);
    end
  endtask

  // One input cycle plus its expected post-edge outputs.
  task automatic step(input string name, input bit r, input bit v, input int val,
                      input int eSinc, input int eErr, input int eIdx, input int eVue);
    expT e;
    @(negedge C);
    R      = r;
    Valido = v;
    Valor  = 4'(val);
    e.name   = name;
    e.sinc   = eSinc;
    e.err    = eErr;
    e.idx    = eIdx;
    e.esp    = secRef[eIdx];
    e.vue    = eVue;
    e.vueSat = (eVue > 3) ? 3 : eVue;
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, compare one entry per edge.
  initial begin
    expT e;
    forever begin
      @(posedge C);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("txn %s: sinc=%0d err=%0d idx=%0d esp=%0d vue=%0d vueSat=%0d",
                 e.name, sinc1, err1, idx1, esp1, vue1, vue2);
        check({e.name, " sinc"},   int'(sinc1), e.sinc);
        check({e.name, " err"},    int'(err1),  e.err);
        check({e.name, " idx"},    int'(idx1),  e.idx);
        check({e.name, " esp"},    int'(esp1),  e.esp);
        check({e.name, " vue"},    int'(vue1),  e.vue);
        check({e.name, " sinc2"},  int'(sinc2), e.sinc);
        check({e.name, " idx2"},   int'(idx2),  e.idx);
        check({e.name, " vueSat"}, int'(vue2),  e.vueSat);
      end
    end
  end

  initial begin
    int espera;
    // Reset state
    step("reset", 1, 0, 0, 0, 0, 0, 0);

    // 1: one clean period plus the next 3
    step("t1 v3",  0, 1, 3,  1, 0, 1, 0);
    step("t1 v7",  0, 1, 7,  1, 0, 2, 0);
    step("t1 v6a", 0, 1, 6,  1, 0, 3, 0);
    step("t1 v6b", 0, 1, 6,  1, 0, 4, 0);
    step("t1 v15", 0, 1, 15, 1, 0, 5, 0);
    step("t1 v14", 0, 1, 14, 1, 0, 6, 0);
    step("t1 v7b", 0, 1, 7,  1, 0, 7, 0);
    step("t1 v10", 0, 1, 10, 1, 0, 8, 0);
    step("t1 v12", 0, 1, 12, 1, 0, 9, 0);
    step("t1 v14b",0, 1, 14, 1, 0, 0, 1);
    step("t1 v3b", 0, 1, 3,  1, 0, 1, 1);

    // 2: single corrupted sample at position 4
    step("t2 v7",  0, 1, 7,  1, 0, 2, 1);
    step("t2 v6a", 0, 1, 6,  1, 0, 3, 1);
    step("t2 v6b", 0, 1, 6,  1, 0, 4, 1);
    step("t2 bad9",0, 1, 9,  1, 1, 5, 1);
    step("t2 v14", 0, 1, 14, 1, 0, 6, 1);
    step("t2 v7b", 0, 1, 7,  1, 0, 7, 1);

    // 3: three consecutive mismatches drop the lock
    step("t3 bad1",0, 1, 0,  1, 1, 8, 1);
    step("t3 bad2",0, 1, 0,  1, 1, 9, 1);
    step("t3 bad3",0, 1, 0,  0, 1, 0, 1);
    step("t3 idle",0, 0, 0,  0, 0, 0, 1);

    // 4: hunting ignores everything but 3
    step("t4 rst", 1, 0, 0,  0, 0, 0, 0);
    step("t4 v7",  0, 1, 7,  0, 0, 0, 0);
    step("t4 v6a", 0, 1, 6,  0, 0, 0, 0);
    step("t4 v6b", 0, 1, 6,  0, 0, 0, 0);
    step("t4 v15", 0, 1, 15, 0, 0, 0, 0);
    step("t4 v3",  0, 1, 3,  1, 0, 1, 0);

    // 5: invalid cycles with garbage are ignored
    step("t5 v7",  0, 1, 7,  1, 0, 2, 0);
    step("t5 inv9",0, 0, 9,  1, 0, 2, 0);
    step("t5 v6a", 0, 1, 6,  1, 0, 3, 0);
    step("t5 inv0",0, 0, 0,  1, 0, 3, 0);
    step("t5 inv15",0,0, 15, 1, 0, 3, 0);
    step("t5 v6b", 0, 1, 6,  1, 0, 4, 0);
    step("t5 v15", 0, 1, 15, 1, 0, 5, 0);
    step("t5 v14", 0, 1, 14, 1, 0, 6, 0);
    step("t5 v7b", 0, 1, 7,  1, 0, 7, 0);
    step("t5 v10", 0, 1, 10, 1, 0, 8, 0);
    step("t5 v12", 0, 1, 12, 1, 0, 9, 0);
    step("t5 v14b",0, 1, 14, 1, 0, 0, 1);

    // 6: second period, then partway into a third (Indice=6, Vueltas=2)
    for (int i = 0; i < 10; i++)
      step("t6 per2", 0, 1, secRef[i], 1, 0, (i + 1) % 10, (i == 9) ? 2 : 1);
    for (int i = 0; i < 6; i++)
      step("t6 part", 0, 1, secRef[i], 1, 0, i + 1, 2);
    step("t6 rst",  1, 1, 7,  0, 0, 0, 0);
    step("t6 idle", 0, 0, 3,  0, 0, 0, 0);

    // 6b: five full periods; the 2-bit counter must stop at 3
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 10; i++)
        step("t6 sat", 0, 1, secRef[i], 1, 0, (i + 1) % 10, (i == 9) ? p + 1 : p);
    step("t6 end", 0, 0, 0, 1, 0, 0, 5);

    espera = 0;
    while (q.size() > 0 && espera < 10) begin
      @(negedge C);
      espera++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
